// File: rtl/axil_simplebus_bridge_pkg.sv
// ---------------------------------------------------------------------------
// axil_simplebus_bridge_pkg
// Shared types and constants for the AXI-Lite to Simplebus bridge:
//   state_e      - bridge FSM states
//   RESP_OKAY    - AXI OKAY response code
//   RESP_SLVERR  - AXI SLVERR response code
//   FULL_STRB    - the only write strobe pattern that reaches the bus
// ---------------------------------------------------------------------------
package axil_simplebus_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_ISSUE,
        WR_RESP,
        RD_ISSUE,
        RD_WAIT,
        RD_RESP
    } state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [3:0] FULL_STRB   = 4'hF;

endpackage

// File: rtl/axil_simplebus_bridge_if.sv
// ---------------------------------------------------------------------------
// Bus interfaces used by the bridge.
//   axi_lite  - 32-bit data AXI-Lite port (AW, W, B, AR, R channels),
//               address width set by ADDR_WIDTH.
//               modport slave : bridge side, master : interconnect side.
//   Simplebus - 32-bit strobe bus toward the register-file peripherals.
//               outputs of master: sb_address, sb_write_strobe,
//               sb_write_data, sb_read_strobe;
//               inputs of master : sb_ready, sb_read_valid, sb_read_data.
// ---------------------------------------------------------------------------
interface axi_lite #(
    parameter int ADDR_WIDTH = 32
) ();
    import axil_simplebus_bridge_pkg::*;

    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [31:0]           rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

interface Simplebus ();
    logic [31:0] sb_address;
    logic        sb_write_strobe;
    logic [31:0] sb_write_data;
    logic        sb_read_strobe;
    logic        sb_ready;
    logic        sb_read_valid;
    logic [31:0] sb_read_data;

    modport master (
        output sb_address, sb_write_strobe, sb_write_data, sb_read_strobe,
        input  sb_ready, sb_read_valid, sb_read_data
    );

    modport slave (
        input  sb_address, sb_write_strobe, sb_write_data, sb_read_strobe,
        output sb_ready, sb_read_valid, sb_read_data
    );
endinterface

// File: rtl/axil_simplebus_bridge.sv
// ---------------------------------------------------------------------------
// axil_simplebus_bridge
// Converts single-beat AXI-Lite reads/writes into single-cycle Simplebus
// strobes, one transaction in flight at a time.
// Ports:
//   clock   - system clock, rising edge
//   reset   - asynchronous, active-high
//   axi_in  - AXI-Lite slave port (upstream interconnect)
//   sb_out  - Simplebus master port (downstream register files)
// Parameters:
//   READ_TIMEOUT - RD_WAIT cycles before a read is answered with SLVERR
//   ADDR_WIDTH   - AXI address width, zero-extended onto sb_address
// Every output is a flop; the next-state logic computes what each output
// must be during the *next* state, so e.g. AWREADY is high exactly in
// WR_ISSUE and BVALID rises on entry to WR_RESP.
// ---------------------------------------------------------------------------
module axil_simplebus_bridge
    import axil_simplebus_bridge_pkg::*;
#(
    parameter int READ_TIMEOUT = 255,
    parameter int ADDR_WIDTH   = 32
) (
    input  logic     clock,
    input  logic     reset,
    axi_lite.slave   axi_in,
    Simplebus.master sb_out
);

    localparam logic [15:0] TMO_LIMIT = 16'(READ_TIMEOUT);

    state_e      state_q, state_d;
    logic        last_was_write_q, last_was_write_d;
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic [15:0] tmo_cnt_inc;

    logic        awready_q, awready_d;
    logic        wready_q, wready_d;
    logic        arready_q, arready_d;
    logic        bvalid_q, bvalid_d;
    logic [1:0]  bresp_q, bresp_d;
    logic        rvalid_q, rvalid_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  rresp_q, rresp_d;
    logic [31:0] sb_addr_q, sb_addr_d;
    logic        sb_wstrobe_q, sb_wstrobe_d;
    logic [31:0] sb_wdata_q, sb_wdata_d;
    logic        sb_rstrobe_q, sb_rstrobe_d;

    logic [ADDR_WIDTH-1:0] awaddr_w, araddr_w;
    logic                  wr_elig, rd_elig;

    assign awaddr_w = axi_in.awaddr;
    assign araddr_w = axi_in.araddr;
    assign wr_elig  = axi_in.awvalid & axi_in.wvalid & sb_out.sb_ready;
    assign rd_elig  = axi_in.arvalid & sb_out.sb_ready;

    // Counter never wraps, so a huge READ_TIMEOUT still terminates.
    assign tmo_cnt_inc = (tmo_cnt_q == 16'hFFFF) ? tmo_cnt_q : tmo_cnt_q + 16'd1;

    always_comb begin
        state_d          = state_q;
        last_was_write_d = last_was_write_q;
        tmo_cnt_d        = tmo_cnt_q;
        awready_d        = 1'b0;
        wready_d         = 1'b0;
        arready_d        = 1'b0;
        bvalid_d         = 1'b0;
        bresp_d          = bresp_q;
        rvalid_d         = 1'b0;
        rdata_d          = rdata_q;
        rresp_d          = rresp_q;
        sb_addr_d        = 32'h0;
        sb_wstrobe_d     = 1'b0;
        sb_wdata_d       = 32'h0;
        sb_rstrobe_d     = 1'b0;

        case (state_q)
            IDLE: begin
                // On contention the flag makes reads and writes alternate.
                if (wr_elig && (!rd_elig || !last_was_write_q)) begin
                    state_d          = WR_ISSUE;
                    last_was_write_d = 1'b1;
                    awready_d        = 1'b1;
                    wready_d         = 1'b1;
                    if (axi_in.wstrb == FULL_STRB) begin
                        sb_wstrobe_d = 1'b1;
                        sb_addr_d    = 32'(awaddr_w);
                        sb_wdata_d   = axi_in.wdata;
                        bresp_d      = RESP_OKAY;
                    end else begin
                        // Peripherals have no byte lanes: refuse partial writes.
                        bresp_d      = RESP_SLVERR;
                    end
                end else if (rd_elig) begin
                    state_d          = RD_ISSUE;
                    last_was_write_d = 1'b0;
                    arready_d        = 1'b1;
                    sb_rstrobe_d     = 1'b1;
                    sb_addr_d        = 32'(araddr_w);
                end
            end
            WR_ISSUE: begin
                state_d  = WR_RESP;
                bvalid_d = 1'b1;
            end
            WR_RESP: begin
                if (axi_in.bready) begin
                    state_d = IDLE;
                end else begin
                    bvalid_d = 1'b1;
                end
            end
            RD_ISSUE: begin
                state_d   = RD_WAIT;
                tmo_cnt_d = 16'h0;
            end
            RD_WAIT: begin
                if (sb_out.sb_read_valid) begin
                    state_d  = RD_RESP;
                    rvalid_d = 1'b1;
                    rdata_d  = sb_out.sb_read_data;
                    rresp_d  = RESP_OKAY;
                end else begin
                    tmo_cnt_d = tmo_cnt_inc;
                    if (tmo_cnt_inc >= TMO_LIMIT) begin
                        state_d  = RD_RESP;
                        rvalid_d = 1'b1;
                        rdata_d  = 32'h0;
                        rresp_d  = RESP_SLVERR;
                    end
                end
            end
            RD_RESP: begin
                if (axi_in.rready) begin
                    state_d = IDLE;
                end else begin
                    rvalid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            last_was_write_q <= 1'b0;
            tmo_cnt_q        <= 16'h0;
            awready_q        <= 1'b0;
            wready_q         <= 1'b0;
            arready_q        <= 1'b0;
            bvalid_q         <= 1'b0;
            bresp_q          <= 2'b00;
            rvalid_q         <= 1'b0;
            rdata_q          <= 32'h0;
            rresp_q          <= 2'b00;
            sb_addr_q        <= 32'h0;
            sb_wstrobe_q     <= 1'b0;
            sb_wdata_q       <= 32'h0;
            sb_rstrobe_q     <= 1'b0;
        end else begin
            state_q          <= state_d;
            last_was_write_q <= last_was_write_d;
            tmo_cnt_q        <= tmo_cnt_d;
            awready_q        <= awready_d;
            wready_q         <= wready_d;
            arready_q        <= arready_d;
            bvalid_q         <= bvalid_d;
            bresp_q          <= bresp_d;
            rvalid_q         <= rvalid_d;
            rdata_q          <= rdata_d;
            rresp_q          <= rresp_d;
            sb_addr_q        <= sb_addr_d;
            sb_wstrobe_q     <= sb_wstrobe_d;
            sb_wdata_q       <= sb_wdata_d;
            sb_rstrobe_q     <= sb_rstrobe_d;
        end
    end

    assign axi_in.awready         = awready_q;
    assign axi_in.wready          = wready_q;
    assign axi_in.arready         = arready_q;
    assign axi_in.bvalid          = bvalid_q;
    assign axi_in.bresp           = bresp_q;
    assign axi_in.rvalid          = rvalid_q;
    assign axi_in.rdata           = rdata_q;
    assign axi_in.rresp           = rresp_q;
    assign sb_out.sb_address      = sb_addr_q;
    assign sb_out.sb_write_strobe = sb_wstrobe_q;
    assign sb_out.sb_write_data   = sb_wdata_q;
    assign sb_out.sb_read_strobe  = sb_rstrobe_q;

endmodule

// File: tb/tb_axil_simplebus_bridge.sv
// ---------------------------------------------------------------------------
// tb_axil_simplebus_bridge
// Scoreboard bench: stimulus tasks push expected B/R responses, expected
// Simplebus strobes and slave behaviour into queues; independent drivers
// and monitors consume them. Arbitration order is predicted by a small
// alternation model over pending request counts.
// ---------------------------------------------------------------------------
module tb_axil_simplebus_bridge;
    import axil_simplebus_bridge_pkg::*;

    localparam int TMO = 10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   spurious_en = 1'b0;
    int   resp_at = -1;
    logic [31:0] resp_data = 32'h0;
    bit   model_lastw = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    axi_lite #(.ADDR_WIDTH(32)) axi ();
    Simplebus sb ();

    axil_simplebus_bridge #(.READ_TIMEOUT(TMO), .ADDR_WIDTH(32)) dut (
        .clock (clk),
        .reset (rst),
        .axi_in(axi),
        .sb_out(sb)
    );

    typedef struct { logic [31:0] addr; logic [31:0] data; logic [3:0] strb; int lag; int ready_low; } wr_req_t;
    typedef struct { logic [1:0] resp; int bdly; int lat; } b_exp_t;
    typedef struct { logic [31:0] data; logic [1:0] resp; int rdly; int lat; int tol; } r_exp_t;
    typedef struct { bit silent; int delay; logic [31:0] data; } sl_t;

    wr_req_t     wr_pend[$];
    logic [31:0] rd_pend[$];
    b_exp_t      exp_b[$];
    r_exp_t      exp_r[$];
    logic [63:0] exp_sbw[$];
    logic [31:0] exp_ra[$];
    sl_t         slave_q[$];
    int          wr_t0[$];
    int          rd_t0[$];
    bit          grant_log[$];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
        end
    endtask

    task automatic issue_write(logic [31:0] addr, logic [31:0] data, logic [3:0] strb,
                               int lag, int ready_low, int bdly, int lat);
        wr_pend.push_back('{addr, data, strb, lag, ready_low});
        exp_b.push_back('{(strb == 4'hF) ? RESP_OKAY : RESP_SLVERR, bdly, lat});
        if (strb == 4'hF) exp_sbw.push_back({addr, data});
        $display("issue WR addr=%08h data=%08h strb=%h", addr, data, strb);
    endtask

    task automatic issue_read(logic [31:0] addr, bit silent, int delay, logic [31:0] data,
                              int rdly, int lat, int tol, bit abort);
        rd_pend.push_back(addr);
        exp_ra.push_back(addr);
        slave_q.push_back('{silent, delay, data});
        if (!abort)
            exp_r.push_back('{silent ? 32'h0 : data, silent ? RESP_SLVERR : RESP_OKAY, rdly, lat, tol});
        $display("issue RD addr=%08h silent=%0d delay=%0d data=%08h", addr, silent, delay, data);
    endtask

    task automatic check_all_zero(string tag);
        chk({tag, "_awready"}, axi.awready, 0);
        chk({tag, "_wready"},  axi.wready, 0);
        chk({tag, "_arready"}, axi.arready, 0);
        chk({tag, "_bvalid"},  axi.bvalid, 0);
        chk({tag, "_bresp"},   axi.bresp, 0);
        chk({tag, "_rvalid"},  axi.rvalid, 0);
        chk({tag, "_rdata"},   axi.rdata, 0);
        chk({tag, "_rresp"},   axi.rresp, 0);
        chk({tag, "_sb_addr"}, sb.sb_address, 0);
        chk({tag, "_sb_wstb"}, sb.sb_write_strobe, 0);
        chk({tag, "_sb_wdat"}, sb.sb_write_data, 0);
        chk({tag, "_sb_rstb"}, sb.sb_read_strobe, 0);
    endtask

    task automatic drain(string tag);
        int n = 0;
        while ((wr_pend.size() + rd_pend.size() + exp_b.size() + exp_r.size()
                + exp_sbw.size() + exp_ra.size()) != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        chk({tag, "_drain"}, (n < 3000), 1);
        repeat (12) @(posedge clk);
    endtask

    // Write-channel driver; also owns sb_ready.
    initial begin
        axi.awvalid = 0; axi.wvalid = 0; axi.awaddr = 0; axi.wdata = 0; axi.wstrb = 0;
        sb.sb_ready = 1;
        forever begin
            @(posedge clk); #1;
            while (wr_pend.size() > 0) begin
                wr_req_t r;
                int      n;
                bit      hs;
                r = wr_pend.pop_front();
                axi.awaddr = r.addr; axi.wdata = r.data; axi.wstrb = r.strb;
                axi.awvalid = 1; axi.wvalid = (r.lag == 0);
                for (int i = 0; i < r.lag; i++) begin @(posedge clk); #1; end
                axi.wvalid = 1;
                if (r.ready_low > 0) sb.sb_ready = 0;
                wr_t0.push_back(cyc);
                n = 0; hs = 0;
                while (!hs && n < 200) begin
                    @(negedge clk);
                    hs = axi.awready && axi.wready;
                    @(posedge clk); #1;
                    n++;
                    if (n == r.ready_low) sb.sb_ready = 1;
                end
                sb.sb_ready = 1;
                chk("aw_w_handshake", hs, 1);
            end
            axi.awvalid = 0; axi.wvalid = 0;
        end
    end

    // Read-address driver.
    initial begin
        axi.arvalid = 0; axi.araddr = 0;
        forever begin
            @(posedge clk); #1;
            while (rd_pend.size() > 0) begin
                int n;
                bit hs;
                axi.araddr = rd_pend.pop_front();
                axi.arvalid = 1;
                rd_t0.push_back(cyc);
                n = 0; hs = 0;
                while (!hs && n < 200) begin
                    @(negedge clk);
                    hs = axi.arready;
                    @(posedge clk); #1;
                    n++;
                end
                chk("ar_handshake", hs, 1);
            end
            axi.arvalid = 0;
        end
    end

    // Simplebus slave: answers a read strobe after the scheduled delay.
    initial begin
        sb.sb_read_valid = 0; sb.sb_read_data = 0;
        forever begin
            @(posedge clk); #1;
            sb.sb_read_valid = 0; sb.sb_read_data = 0;
            if (resp_at == cyc) begin
                sb.sb_read_valid = 1; sb.sb_read_data = resp_data;
            end else if (spurious_en) begin
                sb.sb_read_valid = 1'($urandom_range(0, 1)); sb.sb_read_data = $urandom;
            end
        end
    end

    // Strobe / grant monitor.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (axi.awready) begin
                    grant_log.push_back(1'b1);
                    chk("aw_grant_with_w", {axi.wvalid, axi.wready}, 2'b11);
                end
                if (axi.arready) grant_log.push_back(1'b0);
                if (sb.sb_write_strobe && sb.sb_read_strobe) chk("sb_strobe_overlap", 1, 0);
                if (sb.sb_write_strobe) begin
                    if (exp_sbw.size() == 0) chk("sb_write_unexpected", 1, 0);
                    else begin
                        logic [63:0] e;
                        e = exp_sbw.pop_front();
                        chk("sb_write_addr_data", {sb.sb_address, sb.sb_write_data}, e);
                        $display("sb WR addr=%08h data=%08h", sb.sb_address, sb.sb_write_data);
                    end
                end
                if (sb.sb_read_strobe) begin
                    if (exp_ra.size() == 0 || slave_q.size() == 0) chk("sb_read_unexpected", 1, 0);
                    else begin
                        sl_t s;
                        chk("sb_read_addr", sb.sb_address, exp_ra.pop_front());
                        chk("sb_read_wdata_zero", sb.sb_write_data, 0);
                        s = slave_q.pop_front();
                        if (!s.silent) begin
                            resp_at = cyc + s.delay;
                            resp_data = s.data;
                        end
                    end
                end
                if (!sb.sb_write_strobe && !sb.sb_read_strobe)
                    chk("sb_idle_zero", {sb.sb_address, sb.sb_write_data}, 64'h0);
            end
        end
    end

    // B-channel monitor: checks response and latency, drives BREADY.
    initial begin
        axi.bready = 0;
        forever begin
            @(negedge clk);
            if (!rst && axi.bvalid) begin
                b_exp_t     e;
                int         t0;
                logic [1:0] held;
                if (exp_b.size() == 0) begin
                    chk("b_unexpected", 1, 0);
                    e = '{RESP_OKAY, 0, -1};
                end else e = exp_b.pop_front();
                t0 = (wr_t0.size() > 0) ? wr_t0.pop_front() : cyc;
                chk("bresp", axi.bresp, e.resp);
                if (e.lat >= 0) chk("b_latency", cyc - t0, e.lat);
                $display("B resp=%0b lat=%0d", axi.bresp, cyc - t0);
                held = axi.bresp;
                for (int i = 0; i < e.bdly; i++) begin
                    @(posedge clk); @(negedge clk);
                    chk("b_hold", {axi.bvalid, axi.bresp}, {1'b1, held});
                end
                @(posedge clk); #1; axi.bready = 1;
                @(posedge clk); #1; axi.bready = 0;
            end
        end
    end

    // R-channel monitor: checks data/response/latency, drives RREADY.
    initial begin
        axi.rready = 0;
        forever begin
            @(negedge clk);
            if (!rst && axi.rvalid) begin
                r_exp_t      e;
                int          t0;
                int          lat;
                logic [33:0] held;
                if (exp_r.size() == 0) begin
                    chk("r_unexpected", 1, 0);
                    e = '{32'h0, RESP_OKAY, 0, -1, 0};
                end else e = exp_r.pop_front();
                t0 = (rd_t0.size() > 0) ? rd_t0.pop_front() : cyc;
                lat = cyc - t0;
                chk("r_data_resp", {axi.rresp, axi.rdata}, {e.resp, e.data});
                if (e.lat >= 0) chk("r_latency", (lat >= e.lat) && (lat <= e.lat + e.tol), 1);
                $display("R data=%08h resp=%0b lat=%0d", axi.rdata, axi.rresp, lat);
                held = {axi.rresp, axi.rdata};
                for (int i = 0; i < e.rdly; i++) begin
                    @(posedge clk); @(negedge clk);
                    chk("r_hold", {axi.rvalid, axi.rresp, axi.rdata}, {1'b1, held});
                end
                @(posedge clk); #1; axi.rready = 1;
                @(posedge clk); #1; axi.rready = 0;
            end
        end
    end

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog actual=running required=finished cycle=%0d", cyc);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        bit exp_ord[$];
        bit lw;
        int nw;
        int nr;
        int n;
        bit got;

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 0;
        repeat (3) @(posedge clk);

        // Full write, spurious read-valids must be ignored.
        spurious_en = 1;
        issue_write(32'h43C0_0004, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 2);
        drain("wr_basic");
        spurious_en = 0;
        model_lastw = 1;

        // Reads: slave 2 cycles late with RREADY delayed 5; silent slave; fastest slave.
        issue_read(32'h43C0_0008, 0, 2, 32'h1234_5678, 5, 4, 0, 0);
        drain("rd_basic");
        issue_read(32'h43C0_000C, 1, 0, 32'h0, 0, 2 + TMO, 1, 0);
        drain("rd_timeout");
        issue_read(32'h43C0_0010, 0, 1, 32'hCAFE_F00D, 0, 3, 0, 0);
        drain("rd_after_timeout");
        model_lastw = 0;

        // Partial strobe, then W lagging AW by 3 cycles.
        spurious_en = 1;
        issue_write(32'h43C0_0014, 32'h5555_AAAA, 4'h3, 0, 0, 1, 2);
        issue_write(32'h43C0_0018, 32'h0BAD_F00D, 4'hF, 3, 0, 0, 2);
        drain("wr_partial_lag");
        spurious_en = 0;

        // sb_ready low for 4 cycles pushes the start out by exactly 4.
        issue_write(32'h43C0_001C, 32'h0000_0001, 4'hF, 0, 4, 0, 6);
        drain("sb_ready_low");
        model_lastw = 1;

        // Contention: three reads and three writes pending together.
        grant_log.delete();
        for (int i = 0; i < 3; i++) begin
            issue_write(32'h4000_0100 + 32'(i * 4), $urandom, 4'hF, 0, 0, 0, -1);
            issue_read(32'h4000_0200 + 32'(i * 4), 0, 1, $urandom, 0, -1, 0, 0);
        end
        drain("contention");
        lw = model_lastw; nw = 3; nr = 3;
        while (nw > 0 || nr > 0) begin
            bit pick_w;
            pick_w = (nw > 0 && nr > 0) ? !lw : (nw > 0);
            exp_ord.push_back(pick_w);
            lw = pick_w;
            if (pick_w) nw--; else nr--;
        end
        model_lastw = lw;
        chk("grant_count", grant_log.size(), exp_ord.size());
        for (int i = 0; i < exp_ord.size() && i < grant_log.size(); i++)
            chk($sformatf("grant_order_%0d", i), grant_log[i], exp_ord[i]);

        // Reset while waiting on a silent slave.
        issue_read(32'h43C0_0020, 1, 0, 32'h0, 0, -1, 0, 1);
        n = 0; got = 0;
        while (!got && n < 100) begin
            @(negedge clk);
            got = axi.arready;
            n++;
        end
        chk("reset_rd_grant", got, 1);
        @(posedge clk); @(posedge clk); #3;
        rst = 1;
        #1;
        check_all_zero("reset_async");
        rd_t0.delete();
        model_lastw = 0;
        repeat (2) @(posedge clk);
        #2 rst = 0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        chk("no_stale_rvalid", axi.rvalid, 0);
        issue_write(32'h43C0_0024, 32'h7777_0000, 4'hF, 0, 0, 0, 2);
        drain("post_reset");
        model_lastw = 1;

        // Randomized mix.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                logic [3:0] strb;
                strb = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 14)) : 4'hF;
                issue_write($urandom & 32'hFFFF_FFFC, $urandom, strb,
                            $urandom_range(0, 2), 0, $urandom_range(0, 3), -1);
            end else begin
                issue_read($urandom & 32'hFFFF_FFFC, ($urandom_range(0, 9) == 0),
                           $urandom_range(1, 8), $urandom, $urandom_range(0, 3), -1, 0, 0);
            end
        end
        drain("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
